seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width; verification runs at WIDTH=8.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port ctrl_div  input  1  start request, sampled on rising clock edge.
REQ-005 SHALL have port data_dividend  input  WIDTH  unsigned dividend, sampled with ctrl_div.
REQ-006 SHALL have port data_divisor  input  WIDTH  unsigned divisor, sampled with ctrl_div.
REQ-007 SHALL have port data_quotient  output  WIDTH  registered quotient of last completed operation.
REQ-008 SHALL have port data_remainder  output  WIDTH  registered remainder of last completed operation.
REQ-009 SHALL have port data_resultRDY  output  1  one-cycle pulse marking new valid result.
REQ-010 SHALL have port data_exception  output  1  divide-by-zero flag for last completed operation.
REQ-011 SHALL have port busy  output  1  high while an iterative divide is in progress.

Function
REQ-012 SHALL implement unsigned restoring division: quotient = dividend / divisor, remainder = dividend mod divisor.
REQ-013 SHALL use two states: IDLE, RUN; busy = 1 exactly in RUN.
REQ-014 SHALL, in IDLE with ctrl_div=1 at edge k and divisor≠0, latch both operands into internal working registers, clear partial remainder and iteration counter, enter RUN.
REQ-015 SHALL, in RUN, perform one iteration per edge: shift {partial remainder, working dividend} left one bit; trial-subtract divisor from the WIDTH+1-bit partial remainder via two's-complement addition (add ~divisor + 1); no borrow -> keep difference, shift in quotient bit 1; borrow -> restore, shift in 0.
REQ-016 SHALL complete exactly WIDTH iterations on edges k+1..k+WIDTH; at edge k+WIDTH load data_quotient/data_remainder, set data_resultRDY=1, data_exception=0, return to IDLE.
REQ-017 SHALL keep data_resultRDY high for exactly one cycle, cleared at the following edge unless a new completion occurs on it.
REQ-018 SHALL, in IDLE with ctrl_div=1 at edge k and divisor=0, skip RUN: at edge k set data_quotient=0, data_remainder=dividend, data_exception=1, data_resultRDY=1 (latency 1 cycle).
REQ-019 SHALL ignore ctrl_div while in RUN; operands and progress of current operation unaffected.
REQ-020 SHALL accept ctrl_div in the cycle data_resultRDY is high (state IDLE), enabling back-to-back operations every WIDTH+1 cycles.
REQ-021 SHALL hold data_quotient, data_remainder, data_exception stable from one completion to the next; intermediate working values never visible on outputs.
REQ-022 SHALL ignore operand input changes after the sampling edge.
REQ-023 SHALL size the iteration counter ceil(log2(WIDTH+1)) bits with no wrap during an operation.

Reset
REQ-024 SHALL, on reset assertion, immediately (asynchronously) force state IDLE, busy=0, data_resultRDY=0, data_exception=0, data_quotient=0, data_remainder=0, and clear working registers and counter.
REQ-025 SHALL abort any in-progress operation on reset with no data_resultRDY pulse for it.
REQ-026 SHALL accept ctrl_div on the first rising edge after reset deassertion.

Verification
REQ-027 SHALL check 100 / 7 started at edge k -> busy high edges k..k+7, data_resultRDY=1 after edge k+8 for one cycle, quotient=14, remainder=2, exception=0.
REQ-028 SHALL check 255 / 1 -> quotient=255, remainder=0; and 200 / 255 -> quotient=0, remainder=200.
REQ-029 SHALL check 5 / 0 -> after edge k: data_resultRDY=1, exception=1, quotient=0, remainder=5, busy never asserted.
REQ-030 SHALL check ctrl_div pulsed with 9 / 3 at edge k+3 of a running 100 / 7 -> ignored; result 14 r 2 only.
REQ-031 SHALL check ctrl_div asserted in the data_resultRDY cycle with 9 / 3 -> second result quotient=3, remainder=0, exactly 9 cycles after first.
REQ-032 SHALL check reset asserted mid-edge k+4 of 100 / 7 -> outputs immediately 0, no data_resultRDY pulse, next 100 / 7 correct.

Source files
------------

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// A zero divisor bypasses the iteration and reports an exception one edge after the request.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_dividend,
    input  logic [WIDTH-1:0] data_divisor,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_prem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_rdy;
    logic             r_exc;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_nobrw;
    logic [WIDTH-1:0] w_prem_next;
    logic [WIDTH-1:0] w_work_next;

    // r_work holds the remaining dividend bits in its upper part and collects
    // quotient bits from the bottom, so after WIDTH shifts it is the quotient.
    // The partial remainder is always below the divisor, so the sign bit of the
    // WIDTH+1-bit difference is exactly the borrow.
    always_comb begin
        w_trial     = {r_prem, r_work[WIDTH-1]};
        w_diff      = w_trial + ~{1'b0, r_divisor} + (WIDTH + 1)'(1);
        w_nobrw     = ~w_diff[WIDTH];
        w_prem_next = w_nobrw ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_work_next = (r_work << 1) | WIDTH'(w_nobrw);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_divisor <= '0;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_rdy     <= 1'b0;
            r_exc     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_div) begin
                        if (data_divisor == '0) begin
                            r_quot <= '0;
                            r_rem  <= data_dividend;
                            r_exc  <= 1'b1;
                            r_rdy  <= 1'b1;
                        end else begin
                            r_work    <= data_dividend;
                            r_divisor <= data_divisor;
                            r_prem    <= '0;
                            r_cnt     <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_prem <= w_prem_next;
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_quot  <= w_work_next;
                        r_rem   <= w_prem_next;
                        r_exc   <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_quotient  = r_quot;
    assign data_remainder = r_rem;
    assign data_resultRDY = r_rdy;
    assign data_exception = r_exc;
    assign busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized operations
// checked against plain integer division.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_div;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         rdy;
    logic         exc;
    logic         busy;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_dividend  (dividend),
        .data_divisor   (divisor),
        .data_quotient  (quotient),
        .data_remainder (remainder),
        .data_resultRDY (rdy),
        .data_exception (exc),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives a request for one edge, then scrambles the operand inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_div = 1'b1;
        dividend = a;
        divisor  = b;
        tick;
        ctrl_div = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({quotient, remainder, exc, rdy, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async got q=%h r=%h e=%b v=%b b=%b exp all 0", quotient, remainder, exc, rdy, busy);
        end
        tick;
        tick;
        checks++;
        if ({quotient, remainder, exc, rdy, busy} !== '0) begin
            errors++;
            $display("FAIL reset_held got q=%h r=%h e=%b v=%b b=%b exp all 0", quotient, remainder, exc, rdy, busy);
        end
        ctrl_div = 1'b1;
        dividend = W'(100);
        divisor  = W'(7);
        #3 reset = 1'b0;
        tick;
        ctrl_div = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_accept got busy=%b exp 1", busy);
        end
        repeat (W) tick;
        checks++;
        if ({rdy, quotient, remainder} !== {1'b1, W'(100 / 7), W'(100 % 7)}) begin
            errors++;
            $display("FAIL first_op_result got v=%b q=%0d r=%0d exp v=1 q=14 r=2", rdy, quotient, remainder);
        end
        tick;
    endtask

    task automatic test_basic;
        start_op(W'(100), W'(7));
        for (int i = 0; i < W; i++) begin
            checks++;
            if ({busy, rdy} !== 2'b10) begin
                errors++;
                $display("FAIL basic_run[%0d] got busy=%b rdy=%b exp busy=1 rdy=0", i, busy, rdy);
            end
            tick;
        end
        checks++;
        if ({busy, rdy, exc, quotient, remainder} !== {1'b0, 1'b1, 1'b0, W'(14), W'(2)}) begin
            errors++;
            $display("FAIL basic_done got b=%b v=%b e=%b q=%0d r=%0d exp 0 1 0 14 2", busy, rdy, exc, quotient, remainder);
        end
        tick;
        checks++;
        if ({busy, rdy, quotient, remainder} !== {1'b0, 1'b0, W'(14), W'(2)}) begin
            errors++;
            $display("FAIL basic_pulse got b=%b v=%b q=%0d r=%0d exp 0 0 14 2", busy, rdy, quotient, remainder);
        end
    endtask

    task automatic test_corners;
        start_op(W'(255), W'(1));
        repeat (W) tick;
        checks++;
        if ({rdy, exc, quotient, remainder} !== {1'b1, 1'b0, W'(255), W'(0)}) begin
            errors++;
            $display("FAIL div_by_one got v=%b e=%b q=%0d r=%0d exp 1 0 255 0", rdy, exc, quotient, remainder);
        end
        tick;
        start_op(W'(200), W'(255));
        repeat (W) tick;
        checks++;
        if ({rdy, exc, quotient, remainder} !== {1'b1, 1'b0, W'(0), W'(200)}) begin
            errors++;
            $display("FAIL small_dividend got v=%b e=%b q=%0d r=%0d exp 1 0 0 200", rdy, exc, quotient, remainder);
        end
        tick;
    endtask

    task automatic test_div_zero;
        start_op(W'(5), W'(0));
        checks++;
        if ({busy, rdy, exc, quotient, remainder} !== {1'b0, 1'b1, 1'b1, W'(0), W'(5)}) begin
            errors++;
            $display("FAIL div_zero got b=%b v=%b e=%b q=%0d r=%0d exp 0 1 1 0 5", busy, rdy, exc, quotient, remainder);
        end
        tick;
        checks++;
        if ({busy, rdy, exc, quotient, remainder} !== {1'b0, 1'b0, 1'b1, W'(0), W'(5)}) begin
            errors++;
            $display("FAIL div_zero_hold got b=%b v=%b e=%b q=%0d r=%0d exp 0 0 1 0 5", busy, rdy, exc, quotient, remainder);
        end
    endtask

    task automatic test_ignore_ctrl;
        int pulses;
        start_op(W'(100), W'(7));
        tick;
        tick;
        ctrl_div = 1'b1;
        dividend = W'(9);
        divisor  = W'(3);
        tick;
        ctrl_div = 1'b0;
        repeat (W - 3) tick;
        checks++;
        if ({rdy, exc, quotient, remainder} !== {1'b1, 1'b0, W'(14), W'(2)}) begin
            errors++;
            $display("FAIL ignore_ctrl got v=%b e=%b q=%0d r=%0d exp 1 0 14 2", rdy, exc, quotient, remainder);
        end
        pulses = 0;
        repeat (12) begin
            tick;
            if (rdy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL ignore_extra_result got %0d pulses exp 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(W'(100), W'(7));
        repeat (W) tick;
        checks++;
        if ({rdy, quotient, remainder} !== {1'b1, W'(14), W'(2)}) begin
            errors++;
            $display("FAIL b2b_first got v=%b q=%0d r=%0d exp 1 14 2", rdy, quotient, remainder);
        end
        start_op(W'(9), W'(3));
        lat = 0;
        while (rdy !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        checks++;
        if ({rdy, exc, quotient, remainder} !== {1'b1, 1'b0, W'(3), W'(0)}) begin
            errors++;
            $display("FAIL b2b_second got v=%b e=%b q=%0d r=%0d exp 1 0 3 0", rdy, exc, quotient, remainder);
        end
        checks++;
        if (lat + 1 !== W + 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles exp %0d", lat + 1, W + 1);
        end
        tick;
    endtask

    task automatic test_reset_abort;
        int pulses;
        int lat;
        start_op(W'(100), W'(7));
        repeat (3) tick;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({quotient, remainder, exc, rdy, busy} !== '0) begin
            errors++;
            $display("FAIL abort_async got q=%h r=%h e=%b v=%b b=%b exp all 0", quotient, remainder, exc, rdy, busy);
        end
        tick;
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            tick;
            if (rdy === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d active cycles exp 0", pulses);
        end
        start_op(W'(100), W'(7));
        lat = 0;
        while (rdy !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        checks++;
        if ({rdy, exc, quotient, remainder} !== {1'b1, 1'b0, W'(14), W'(2)} || lat !== W) begin
            errors++;
            $display("FAIL abort_recover got v=%b e=%b q=%0d r=%0d lat=%0d exp 1 0 14 2 lat=%0d", rdy, exc, quotient, remainder, lat, W);
        end
        tick;
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ee;
        int           elat;
        int           lat;
        int           gap;
        for (int n = 0; n < 60; n++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (n == 0) b = '0;
            if (b == '0) begin
                eq = '0;
                er = a;
                ee = 1'b1;
                elat = 0;
            end else begin
                eq = a / b;
                er = a % b;
                ee = 1'b0;
                elat = W;
            end
            start_op(a, b);
            lat = 0;
            while (rdy !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            checks++;
            if ({rdy, ee == 1'b0 ? 1'b0 : exc, quotient, remainder} !== {1'b1, 1'b0 | (ee & exc), eq, er}
                || exc !== ee) begin
                errors++;
                $display("FAIL rand[%0d] %0d/%0d got v=%b e=%b q=%0d r=%0d exp v=1 e=%b q=%0d r=%0d",
                         n, a, b, rdy, exc, quotient, remainder, ee, eq, er);
            end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL rand_latency[%0d] got %0d exp %0d", n, lat, elat);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) tick;
        end
        tick;
    endtask

    initial begin
        reset    = 1'b1;
        ctrl_div = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset;
        test_basic;
        test_corners;
        test_div_zero;
        test_ignore_ctrl;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
